// File: rtl/instruction_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit_pkg
// Shared definitions for the fetch stage:
//   - default reset PC and bubble instruction (opcode 0: decoder writes nothing)
//   - 2-bit fetch FSM state encodings
//   - IF/ID pipeline register operation codes
//   - word alignment helper used for redirect targets
// -----------------------------------------------------------------------------
package instruction_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT     = 32'h0000_0000;
    localparam logic [31:0] BUBBLE_INSTR_DEFAULT = 32'h0000_0000;

    // Fetch FSM: FETCH issues from PC, WAIT keeps a missed request alive,
    // HOLD parks a completed instruction while the hazard unit stalls.
    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_WAIT  = 2'b01,
        ST_HOLD  = 2'b10
    } fetch_state_e;

    // IF/ID register operation selected by the fetch FSM each cycle.
    typedef enum logic [1:0] {
        IFID_HOLD  = 2'b00,
        IFID_LOAD  = 2'b01,
        IFID_FLUSH = 2'b10
    } ifid_op_e;

    // Force an address onto a 4-byte boundary (low two bits cleared).
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if_id_pipeline_reg.sv
// -----------------------------------------------------------------------------
// if_id_pipeline_reg
// IF/ID pipeline register (instruction 32 + PC 32 + valid 1).
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset (loads a bubble)
//   op           in   IFID_LOAD / IFID_HOLD / IFID_FLUSH
//   load_instr   in   instruction captured on IFID_LOAD
//   load_pc      in   address captured on IFID_LOAD
//   instruction  out  registered instruction to decoder
//   pc           out  registered address of instruction
//   valid        out  0 = bubble
// -----------------------------------------------------------------------------
module if_id_pipeline_reg
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] BUBBLE_INSTR = BUBBLE_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  ifid_op_e    op,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic        valid
);

    logic [31:0] instr_r;
    logic [31:0] pc_r;
    logic        valid_r;

    // IF/ID storage: reset and flush both leave a bubble with PC 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_r <= BUBBLE_INSTR;
            pc_r    <= 32'h0000_0000;
            valid_r <= 1'b0;
        end else begin
            case (op)
                IFID_LOAD: begin
                    instr_r <= load_instr;
                    pc_r    <= load_pc;
                    valid_r <= 1'b1;
                end
                IFID_FLUSH: begin
                    instr_r <= BUBBLE_INSTR;
                    pc_r    <= 32'h0000_0000;
                    valid_r <= 1'b0;
                end
                IFID_HOLD: begin
                    instr_r <= instr_r;
                    pc_r    <= pc_r;
                    valid_r <= valid_r;
                end
                default: begin
                    instr_r <= BUBBLE_INSTR;
                    pc_r    <= 32'h0000_0000;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign instruction = instr_r;
    assign pc          = pc_r;
    assign valid       = valid_r;

endmodule

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
// Fetch stage: owns the PC, issues instruction-memory reads over a
// read/busywait handshake and feeds the decoder through the IF/ID register.
// Handles hazard stalls, EX-stage redirects and bubble insertion; one
// instruction per cycle on memory hits.
// Ports:
//   CLK, RESET          clock / synchronous active-high reset
//   STALL               hold IF/ID and PC
//   BRANCH_TAKEN        redirect fetch to BRANCH_TARGET (low 2 bits ignored)
//   IMEM_READ           read request (state decoded, low during reset)
//   IMEM_ADDRESS        registered word-aligned request address
//   IMEM_READDATA       instruction word, valid on READ & !BUSYWAIT
//   IMEM_BUSYWAIT       memory not ready
//   IF_ID_INSTRUCTION   instruction to decoder / control unit
//   IF_ID_PC            address of IF_ID_INSTRUCTION
//   IF_ID_VALID         0 = bubble
// -----------------------------------------------------------------------------
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
    parameter logic [31:0] BUBBLE_INSTR = BUBBLE_INSTR_DEFAULT
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic        IMEM_READ,
    output logic [31:0] IMEM_ADDRESS,
    input  logic [31:0] IMEM_READDATA,
    input  logic        IMEM_BUSYWAIT,
    output logic [31:0] IF_ID_INSTRUCTION,
    output logic [31:0] IF_ID_PC,
    output logic        IF_ID_VALID
);

    fetch_state_e state_r;
    fetch_state_e state_s;
    logic [31:0]  pc_r;
    logic [31:0]  pc_s;
    logic [31:0]  req_addr_r;
    logic [31:0]  req_addr_s;
    logic         drop_r;
    logic         drop_s;
    logic [31:0]  hold_buf_r;
    logic [31:0]  hold_buf_s;

    ifid_op_e     ifid_op_s;
    logic [31:0]  ifid_instr_s;
    logic [31:0]  ifid_pc_s;

    logic         read_s;
    logic         complete_s;
    logic [31:0]  target_s;

    assign read_s     = (state_r != ST_HOLD);
    assign complete_s = read_s & ~IMEM_BUSYWAIT;
    assign target_s   = word_align(BRANCH_TARGET);

    // Next-state, PC, drop flag, hold buffer and IF/ID operation.
    // Redirect is tested first so it overrides stall and completion.
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        drop_s       = drop_r;
        hold_buf_s   = hold_buf_r;
        ifid_op_s    = IFID_HOLD;
        ifid_instr_s = IMEM_READDATA;
        // In FETCH and WAIT the outstanding request address equals the
        // address of the word coming back (unless it is being dropped).
        ifid_pc_s    = req_addr_r;

        case (state_r)
            ST_FETCH: begin
                if (BRANCH_TAKEN) begin
                    pc_s       = target_s;
                    hold_buf_s = BUBBLE_INSTR;
                    ifid_op_s  = IFID_FLUSH;
                end else if (complete_s) begin
                    if (STALL) begin
                        hold_buf_s = IMEM_READDATA;
                        state_s    = ST_HOLD;
                    end else begin
                        ifid_op_s = IFID_LOAD;
                        pc_s      = pc_r + 32'd4;
                    end
                end else begin
                    state_s = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (BRANCH_TAKEN) begin
                    pc_s       = target_s;
                    hold_buf_s = BUBBLE_INSTR;
                    ifid_op_s  = IFID_FLUSH;
                    if (IMEM_BUSYWAIT) begin
                        // The memory cannot abort; remember to discard the
                        // stale word when it finally arrives.
                        drop_s = 1'b1;
                    end else begin
                        drop_s  = 1'b0;
                        state_s = ST_FETCH;
                    end
                end else if (complete_s) begin
                    if (drop_r) begin
                        drop_s  = 1'b0;
                        state_s = ST_FETCH;
                    end else if (STALL) begin
                        hold_buf_s = IMEM_READDATA;
                        state_s    = ST_HOLD;
                    end else begin
                        ifid_op_s = IFID_LOAD;
                        pc_s      = pc_r + 32'd4;
                        state_s   = ST_FETCH;
                    end
                end else begin
                    state_s = ST_WAIT;
                end
            end

            ST_HOLD: begin
                if (BRANCH_TAKEN) begin
                    pc_s       = target_s;
                    hold_buf_s = BUBBLE_INSTR;
                    ifid_op_s  = IFID_FLUSH;
                    state_s    = ST_FETCH;
                end else if (!STALL) begin
                    ifid_op_s    = IFID_LOAD;
                    ifid_instr_s = hold_buf_r;
                    ifid_pc_s    = pc_r;
                    pc_s         = pc_r + 32'd4;
                    state_s      = ST_FETCH;
                end else begin
                    state_s = ST_HOLD;
                end
            end

            default: begin
                state_s    = ST_FETCH;
                drop_s     = 1'b0;
                hold_buf_s = BUBBLE_INSTR;
                ifid_op_s  = IFID_FLUSH;
            end
        endcase

        // The request address is registered so that no stall/redirect input
        // reaches IMEM_ADDRESS combinationally; it only freezes in WAIT.
        req_addr_s = (state_s == ST_WAIT) ? req_addr_r : pc_s;
    end

    // Fetch state registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r    <= ST_FETCH;
            pc_r       <= RESET_PC;
            req_addr_r <= RESET_PC;
            drop_r     <= 1'b0;
            hold_buf_r <= BUBBLE_INSTR;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            req_addr_r <= req_addr_s;
            drop_r     <= drop_s;
            hold_buf_r <= hold_buf_s;
        end
    end

    assign IMEM_READ    = read_s & ~RESET;
    assign IMEM_ADDRESS = req_addr_r;

    if_id_pipeline_reg #(
        .BUBBLE_INSTR (BUBBLE_INSTR)
    ) u_if_id (
        .clk         (CLK),
        .reset       (RESET),
        .op          (ifid_op_s),
        .load_instr  (ifid_instr_s),
        .load_pc     (ifid_pc_s),
        .instruction (IF_ID_INSTRUCTION),
        .pc          (IF_ID_PC),
        .valid       (IF_ID_VALID)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
// Table-driven vectors for the directed corner cases, followed by a
// scoreboarded stretch of random busywait traffic.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_read;
    logic [31:0] imem_address;
    logic [31:0] imem_readdata;
    logic        imem_busywait;
    logic [31:0] if_id_instruction;
    logic [31:0] if_id_pc;
    logic        if_id_valid;

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .CLK               (clk),
        .RESET             (reset),
        .STALL             (stall),
        .BRANCH_TAKEN      (branch_taken),
        .BRANCH_TARGET     (branch_target),
        .IMEM_READ         (imem_read),
        .IMEM_ADDRESS      (imem_address),
        .IMEM_READDATA     (imem_readdata),
        .IMEM_BUSYWAIT     (imem_busywait),
        .IF_ID_INSTRUCTION (if_id_instruction),
        .IF_ID_PC          (if_id_pc),
        .IF_ID_VALID       (if_id_valid)
    );

    // Memory contents: a distinct word per address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[31:16] ^ 16'h0013};
    endfunction

    // Memory data path responds to whatever address is presented.
    always_comb imem_readdata = mem_word(imem_address);

    typedef struct {
        logic        rst;
        logic        stl;
        logic        br;
        logic [31:0] tgt;
        logic        bw;
        logic        exp_read;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } ifid_t;

    localparam int NVEC = 36;
    vec_t  vecs[NVEC];
    ifid_t sb_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    function automatic vec_t mk(input logic rst, input logic stl, input logic br,
                                input logic [31:0] tgt, input logic bw,
                                input logic rd, input logic [31:0] addr,
                                input logic v, input logic [31:0] pc);
        vec_t r;
        r.rst = rst; r.stl = stl; r.br = br; r.tgt = tgt; r.bw = bw;
        r.exp_read = rd; r.exp_addr = addr; r.exp_valid = v; r.exp_pc = pc;
        return r;
    endfunction

    function automatic ifid_t exp_ifid(input logic v, input logic [31:0] pc);
        ifid_t r;
        r.valid = v;
        r.pc    = v ? pc : 32'h0000_0000;
        r.instr = v ? mem_word(pc) : 32'h0000_0000;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compare_ifid(input string tag);
        ifid_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: scoreboard empty, got pc %h valid %0d", tag, if_id_pc, if_id_valid);
        end else begin
            e = sb_q.pop_front();
            check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, e.valid});
            check({tag, ".pc"}, if_id_pc, e.pc);
            check({tag, ".instr"}, if_id_instruction, e.instr);
        end
    endtask

    initial begin
        logic [31:0] next_pc;
        logic [31:0] addr_exp;
        ifid_t       last;

        //               rst stl br  tgt            bw   rd   addr           v    pc
        vecs[0]  = mk(1'b1,1'b0,1'b0,32'h0,       1'b0,1'b0,32'h0,       1'b0,32'h0);
        vecs[1]  = mk(1'b0,1'b0,1'b0,32'h0,       1'b0,1'b1,32'h0,       1'b1,32'h0);
        vecs[2]  = mk(1'b0,1'b0,1'b0,32'h0,       1'b0,1'b1,32'h4,       1'b1,32'h4);
        vecs[3]  = mk(1'b0,1'b0,1'b0,32'h0,       1'b1,1'b1,32'h8,       1'b1,32'h4);
        vecs[4]  = mk(1'b0,1'b0,1'b0,32'h0,       1'b1,1'b1,32'h8,       1'b1,32'h4);
        vecs[5]  = mk(1'b0,1'b0,1'b0,32'h0,       1'b1,1'b1,32'h8,       1'b1,32'h4);
        vecs[6]  = mk(1'b0,1'b0,1'b0,32'h0,       1'b0,1'b1,32'h8,       1'b1,32'h8);
        vecs[7]  = mk(1'b0,1'b0,1'b0,32'h0,       1'b0,1'b1,32'hC,       1'b1,32'hC);
        vecs[8]  = mk(1'b0,1'b1,1'b0,32'h0,       1'b0,1'b1,32'h10,      1'b1,32'hC);
        vecs[9]  = mk(1'b0,1'b1,1'b0,32'h0,       1'b0,1'b0,32'h10,      1'b1,32'hC);
        vecs[10] = mk(1'b0,1'b0,1'b0,32'h0,       1'b0,1'b0,32'h10,      1'b1,32'h10);
        vecs[11] = mk(1'b0,1'b0,1'b0,32'h0,       1'b0,1'b1,32'h14,      1'b1,32'h14);
        vecs[12] = mk(1'b0,1'b0,1'b0,32'h0,       1'b1,1'b1,32'h18,      1'b1,32'h14);
        vecs[13] = mk(1'b0,1'b0,1'b1,32'h103,     1'b1,1'b1,32'h18,      1'b0,32'h0);
        vecs[14] = mk(1'b0,1'b0,1'b0,32'h0,       1'b1,1'b1,32'h18,      1'b0,32'h0);
        vecs[15] = mk(1'b0,1'b0,1'b0,32'h0,       1'b0,1'b1,32'h18,      1'b0,32'h0);
        vecs[16] = mk(1'b0,1'b0,1'b0,32'h0,       1'b0,1'b1,32'h100,     1'b1,32'h100);
        vecs[17] = mk(1'b0,1'b1,1'b0,32'h0,       1'b0,1'b1,32'h104,     1'b1,32'h100);
        vecs[18] = mk(1'b0,1'b1,1'b1,32'h200,     1'b0,1'b0,32'h104,     1'b0,32'h0);
        vecs[19] = mk(1'b0,1'b0,1'b0,32'h0,       1'b0,1'b1,32'h200,     1'b1,32'h200);
        vecs[20] = mk(1'b0,1'b0,1'b1,32'h300,     1'b0,1'b1,32'h204,     1'b0,32'h0);
        vecs[21] = mk(1'b0,1'b0,1'b0,32'h0,       1'b0,1'b1,32'h300,     1'b1,32'h300);
        vecs[22] = mk(1'b0,1'b0,1'b0,32'h0,       1'b1,1'b1,32'h304,     1'b1,32'h300);
        vecs[23] = mk(1'b0,1'b0,1'b1,32'h400,     1'b0,1'b1,32'h304,     1'b0,32'h0);
        vecs[24] = mk(1'b0,1'b1,1'b0,32'h0,       1'b1,1'b1,32'h400,     1'b0,32'h0);
        vecs[25] = mk(1'b0,1'b1,1'b0,32'h0,       1'b0,1'b1,32'h400,     1'b0,32'h0);
        vecs[26] = mk(1'b0,1'b0,1'b0,32'h0,       1'b0,1'b0,32'h400,     1'b1,32'h400);
        vecs[27] = mk(1'b0,1'b0,1'b0,32'h0,       1'b1,1'b1,32'h404,     1'b1,32'h400);
        vecs[28] = mk(1'b0,1'b0,1'b1,32'h500,     1'b1,1'b1,32'h404,     1'b0,32'h0);
        vecs[29] = mk(1'b0,1'b0,1'b1,32'hFFFF_FFFF,1'b1,1'b1,32'h404,    1'b0,32'h0);
        vecs[30] = mk(1'b0,1'b0,1'b0,32'h0,       1'b0,1'b1,32'h404,     1'b0,32'h0);
        vecs[31] = mk(1'b0,1'b0,1'b0,32'h0,       1'b0,1'b1,32'hFFFF_FFFC,1'b1,32'hFFFF_FFFC);
        vecs[32] = mk(1'b0,1'b0,1'b0,32'h0,       1'b0,1'b1,32'h0,       1'b1,32'h0);
        vecs[33] = mk(1'b0,1'b0,1'b0,32'h0,       1'b1,1'b1,32'h4,       1'b1,32'h0);
        vecs[34] = mk(1'b1,1'b0,1'b0,32'h0,       1'b1,1'b0,32'h4,       1'b0,32'h0);
        vecs[35] = mk(1'b0,1'b0,1'b0,32'h0,       1'b0,1'b1,32'h0,       1'b1,32'h0);

        reset         = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        imem_busywait = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Directed vectors: inputs for one cycle, memory-side outputs during
        // that cycle, IF/ID contents after the closing edge.
        for (int i = 0; i < NVEC; i++) begin
            reset         = vecs[i].rst;
            stall         = vecs[i].stl;
            branch_taken  = vecs[i].br;
            branch_target = vecs[i].tgt;
            imem_busywait = vecs[i].bw;
            sb_q.push_back(exp_ifid(vecs[i].exp_valid, vecs[i].exp_pc));
            @(negedge clk);
            check($sformatf("v%0d.imem_read", i), {31'd0, imem_read}, {31'd0, vecs[i].exp_read});
            check($sformatf("v%0d.imem_address", i), imem_address, vecs[i].exp_addr);
            @(posedge clk);
            #1;
            compare_ifid($sformatf("v%0d", i));
        end

        // Random busywait stream: every hit must deliver the next sequential
        // word exactly once, misses must leave IF/ID untouched.
        reset         = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        next_pc       = 32'h4;
        last          = exp_ifid(1'b1, 32'h0);
        for (int c = 0; c < 40; c++) begin
            imem_busywait = 1'($urandom_range(0, 1));
            addr_exp      = next_pc;
            if (!imem_busywait) begin
                last    = exp_ifid(1'b1, next_pc);
                next_pc = next_pc + 32'd4;
            end
            sb_q.push_back(last);
            @(negedge clk);
            check($sformatf("r%0d.imem_read", c), {31'd0, imem_read}, 32'd1);
            check($sformatf("r%0d.imem_address", c), imem_address, addr_exp);
            @(posedge clk);
            #1;
            compare_ifid($sformatf("r%0d", c));
        end

        check("scoreboard_drained", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
